// File: rtl/decoder_scan_pkg.sv
// ---------------------------------------------------------------------------
// decoder_scan_pkg
// Shared definitions for the decoder scan controller: FSM state encoding and
// the select width / output count of the 3-to-8 decoder being driven.
// ---------------------------------------------------------------------------
package decoder_scan_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_3to8.sv
// ---------------------------------------------------------------------------
// decoder_3to8
// 3-to-8 one-hot decoder with enable. Yi is high when en=1 and {a2,a1,a0}=i.
//   en, a0, a1, a2 in  : enable and select (a0 = LSB)
//   y [7:0]        out : one-hot outputs, all zero when disabled
// ---------------------------------------------------------------------------
module decoder_3to8 (
    input  logic       en,
    input  logic       a0,
    input  logic       a1,
    input  logic       a2,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) y[{a2, a1, a0}] = 1'b1;
    end

endmodule

// File: rtl/scan_next_sel.sv
// ---------------------------------------------------------------------------
// scan_next_sel
// Combinational search for the next select to visit.
//   cur   [2:0] in  : current select
//   mask  [7:0] in  : mask[i]=1 means index i is skipped
//   wrap        in  : 1 = ignore cur and return the lowest unmasked index
//   nxt   [2:0] out : lowest unmasked index above cur (or overall when wrap=1)
//   found       out : nxt is meaningful
// ---------------------------------------------------------------------------
module scan_next_sel
    import decoder_scan_pkg::*;
(
    input  logic [SEL_W-1:0]   cur,
    input  logic [NUM_OUT-1:0] mask,
    input  logic               wrap,
    output logic [SEL_W-1:0]   nxt,
    output logic               found
);

    // Walk downwards so the last candidate written is the lowest one.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (!mask[i] && (wrap || (i > int'(cur)))) begin
                nxt   = i[SEL_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// ---------------------------------------------------------------------------
// decoder_scan_ctrl
// Sequences a 3-bit decoder select through the unmasked outputs, holding each
// select for DWELL cycles. Single sweep (with done pulse) or continuous scan.
//   clk, rst_n      in  : clock, async active-low reset
//   start, stop     in  : begin a scan (in IDLE) / abort a scan
//   mode            in  : 0 = single sweep, 1 = continuous (latched at start)
//   mask [7:0]      in  : mask[i]=1 skips Yi (latched at start)
//   A0, A1, A2      out : decoder select, A0 = LSB
//   sel_valid       out : select is stable and meaningful
//   step            out : pulse on the first cycle of each select period
//   busy            out : high while scanning
//   done            out : pulse when a single sweep finishes
// ---------------------------------------------------------------------------
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int DWELL   = 4,
    parameter int DWELL_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [7:0]   mask,
    output logic         A0,
    output logic         A1,
    output logic         A2,
    output logic         sel_valid,
    output logic         step,
    output logic         busy,
    output logic         done
);

    localparam logic [DWELL_W-1:0] DWELL_M1 = DWELL_W'(DWELL - 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 valid_q, valid_d;
    logic                 step_q, step_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [NUM_OUT-1:0]   mask_q, mask_d;

    logic [SEL_W-1:0]     above_sel, lowest_sel;
    logic                 above_found, lowest_found;
    logic [NUM_OUT-1:0]   lowest_mask;

    // At start the live mask decides the first select; afterwards the latched one.
    assign lowest_mask = (state_q == IDLE) ? mask : mask_q;

    scan_next_sel u_above (
        .cur   (sel_q),
        .mask  (mask_q),
        .wrap  (1'b0),
        .nxt   (above_sel),
        .found (above_found)
    );

    scan_next_sel u_lowest (
        .cur   (sel_q),
        .mask  (lowest_mask),
        .wrap  (1'b1),
        .nxt   (lowest_sel),
        .found (lowest_found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        mask_d  = mask_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start && !stop) begin
                    mode_d = mode;
                    mask_d = mask;
                    if (!lowest_found) begin
                        // Everything masked: nothing to scan, report completion.
                        done_d = 1'b1;
                    end else begin
                        state_d = SCAN;
                        sel_d   = lowest_sel;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        step_d  = 1'b1;
                        cnt_d   = DWELL_M1;
                    end
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (above_found) begin
                    sel_d  = above_sel;
                    cnt_d  = DWELL_M1;
                    step_d = 1'b1;
                end else if (mode_q) begin
                    // With a single unmasked index this reloads the same select.
                    sel_d  = lowest_sel;
                    cnt_d  = DWELL_M1;
                    step_d = 1'b1;
                end else begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
        end
    end

    assign A0        = sel_q[0];
    assign A1        = sel_q[1];
    assign A2        = sel_q[2];
    assign sel_valid = valid_q;
    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_ctrl
// Three controller instances (DWELL = 2, 1, 3) share clock and reset. The
// instance under test drives a 3-to-8 decoder whose one-hot output is checked
// alongside the controller outputs. Expected output words
// {sel_valid, step, busy, done, sel[2:0]} are queued from a sweep model when
// stimulus is applied and popped one per cycle, #1 after each rising edge.
// ---------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start_v [3];
    logic       stop_v  [3];
    logic       mode_v  [3];
    logic [7:0] mask_v  [3];
    logic       a0_v [3], a1_v [3], a2_v [3];
    logic       valid_v [3], step_v [3], busy_v [3], done_v [3];
    logic [6:0] obs [3];

    logic [1:0] cur_inst;
    logic [6:0] cur_obs;
    logic [7:0] y;

    logic [6:0] exp_q [$];
    logic [2:0] held_sel [3];
    int         errors;
    int         checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    decoder_scan_ctrl #(.DWELL(2), .DWELL_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]),
        .mode(mode_v[0]), .mask(mask_v[0]), .A0(a0_v[0]), .A1(a1_v[0]),
        .A2(a2_v[0]), .sel_valid(valid_v[0]), .step(step_v[0]),
        .busy(busy_v[0]), .done(done_v[0])
    );

    decoder_scan_ctrl #(.DWELL(1), .DWELL_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]),
        .mode(mode_v[1]), .mask(mask_v[1]), .A0(a0_v[1]), .A1(a1_v[1]),
        .A2(a2_v[1]), .sel_valid(valid_v[1]), .step(step_v[1]),
        .busy(busy_v[1]), .done(done_v[1])
    );

    decoder_scan_ctrl #(.DWELL(3), .DWELL_W(16)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]),
        .mode(mode_v[2]), .mask(mask_v[2]), .A0(a0_v[2]), .A1(a1_v[2]),
        .A2(a2_v[2]), .sel_valid(valid_v[2]), .step(step_v[2]),
        .busy(busy_v[2]), .done(done_v[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_obs
        assign obs[k] = {valid_v[k], step_v[k], busy_v[k], done_v[k],
                         a2_v[k], a1_v[k], a0_v[k]};
    end

    assign cur_obs = obs[cur_inst];

    decoder_3to8 u_dec (
        .en (cur_obs[6]),
        .a0 (cur_obs[0]),
        .a1 (cur_obs[1]),
        .a2 (cur_obs[2]),
        .y  (y)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one expected word and compare controller outputs and decoder outputs.
    task automatic check_pop(input string tag);
        logic [6:0] e;
        logic [6:0] o;
        logic [7:0] ye;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, got %b", tag, cur_obs);
            return;
        end
        e = exp_q.pop_front();
        o = cur_obs;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s ctrl: got %b expected %b", tag, o, e);
        end
        ye = e[6] ? (8'b1 << e[2:0]) : 8'h00;
        checks++;
        assert (y === ye) else begin
            errors++;
            $error("FAIL %s y: got %b expected %b", tag, y, ye);
        end
    endtask

    task automatic drain_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_pop(tag);
            tick();
        end
    endtask

    task automatic drain_all(input string tag);
        while (exp_q.size() > 0) begin
            check_pop(tag);
            tick();
        end
    endtask

    // Expected sequence after the start edge, built from the sweep definition:
    // each unmasked index in ascending order held for dwell cycles.
    task automatic push_sweep(input int inst, input int dwell, input logic [7:0] m,
                              input logic md, input int cycles);
        int idx [$];
        logic [2:0] s;
        for (int i = 0; i < 8; i++) if (!m[i]) idx.push_back(i);
        if (idx.size() == 0) begin
            exp_q.push_back({4'b0001, held_sel[inst]});
            exp_q.push_back({4'b0000, held_sel[inst]});
            return;
        end
        if (!md) begin
            foreach (idx[k]) begin
                for (int d = 0; d < dwell; d++)
                    exp_q.push_back({1'b1, d == 0, 1'b1, 1'b0, 3'(idx[k])});
            end
            s = 3'(idx[idx.size() - 1]);
            exp_q.push_back({4'b0001, s});
            exp_q.push_back({4'b0000, s});
            held_sel[inst] = s;
        end else begin
            for (int n = 0; n < cycles; n++) begin
                s = 3'(idx[(n / dwell) % idx.size()]);
                exp_q.push_back({1'b1, (n % dwell) == 0, 1'b1, 1'b0, s});
                held_sel[inst] = s;
            end
        end
    endtask

    task automatic start_scan(input int inst, input logic [7:0] m, input logic md);
        cur_inst        = 2'(inst);
        mask_v[inst]    = m;
        mode_v[inst]    = md;
        start_v[inst]   = 1'b1;
        tick();
        start_v[inst]   = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        cur_inst = 2'd0;
        for (int k = 0; k < 3; k++) begin
            start_v[k]  = 1'b0;
            stop_v[k]   = 1'b0;
            mode_v[k]   = 1'b0;
            mask_v[k]   = 8'h00;
            held_sel[k] = 3'd0;
        end

        // Reset values on every instance.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cur_inst = 2'(k);
            #1;
            exp_q.push_back(7'b0);
            check_pop("reset");
        end
        rst_n = 1'b1;
        tick();

        // 1: DWELL=2, full single sweep 0..7, done at cycle 17.
        push_sweep(0, 2, 8'h00, 1'b0, 0);
        start_scan(0, 8'h00, 1'b0);
        drain_all("sweep_d2");

        // 2: DWELL=1, sparse mask, visits 1,3,4,6.
        push_sweep(1, 1, 8'b1010_0101, 1'b0, 0);
        start_scan(1, 8'b1010_0101, 1'b0);
        drain_all("sweep_d1_mask");

        // 3: DWELL=3, single unmasked index, continuous, then stop.
        push_sweep(2, 3, 8'b1111_1101, 1'b1, 20);
        start_scan(2, 8'b1111_1101, 1'b1);
        drain_n(19, "cont_d3");
        check_pop("cont_d3");
        stop_v[2] = 1'b1;
        exp_q.push_back({4'b0000, 3'd1});
        exp_q.push_back({4'b0000, 3'd1});
        tick();
        stop_v[2] = 1'b0;
        drain_all("cont_stop");

        // 4: all masked -> done only; then start with stop in IDLE -> nothing.
        push_sweep(0, 2, 8'hFF, 1'b0, 0);
        start_scan(0, 8'hFF, 1'b0);
        drain_all("all_masked");
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        exp_q.push_back({4'b0000, held_sel[0]});
        exp_q.push_back({4'b0000, held_sel[0]});
        tick();
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        drain_all("start_stop_idle");

        // 5a: restart and mask change at sel=5 are ignored.
        push_sweep(0, 2, 8'h00, 1'b0, 0);
        start_scan(0, 8'h00, 1'b0);
        drain_n(10, "midscan");
        start_v[0] = 1'b1;
        mask_v[0]  = 8'hF0;
        mode_v[0]  = 1'b1;
        drain_n(2, "midscan_restart");
        start_v[0] = 1'b0;
        drain_all("midscan_tail");

        // 5b: async reset at sel=3, then idle after release.
        mask_v[0] = 8'h00;
        mode_v[0] = 1'b0;
        push_sweep(0, 2, 8'h00, 1'b0, 0);
        start_scan(0, 8'h00, 1'b0);
        drain_n(6, "pre_reset");
        check_pop("pre_reset_sel3");
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_q.push_back(7'b0);
        check_pop("async_reset");
        tick();
        rst_n = 1'b1;
        held_sel[0] = 3'd0;
        for (int i = 0; i < 3; i++) exp_q.push_back(7'b0);
        tick();
        drain_all("post_reset_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
